terrain_ram_arbiter: RTL and testbench

//  Owns the single port of the 1-bit terrain (grass-colour) BRAM. Two users share that port:
//  - the video read path, which reads once per pixel during active draw;
//  - the gameplay LFSR fill, which writes a new random map at the start of each hole.

---
 rtl/terrain_ram_arbiter.sv | 121 ++++++++++++
 tb/tb_terrain_ram_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/terrain_ram_arbiter.sv
// Single-port terrain BRAM arbiter: video reads always win, and the LFSR map fill writes
// only in blanking cycles. Tracks fill progress and read-valid timing for the renderer.
module terrain_ram_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned FILL_WORDS  = 3600,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              vid_active_in,
  input  logic [ADDR_W-1:0] vid_addr_in,
  output logic              vid_data_out,
  output logic              vid_valid_out,
  input  logic              fill_start_in,
  input  logic              fill_data_in,
  output logic              fill_ready_out,
  output logic              fill_busy_out,
  output logic              fill_done_out,
  output logic              map_valid_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_din_out,
  output logic              ram_we_out,
  input  logic              ram_dout_in
);

  localparam int unsigned       PipeLen  = RAM_LATENCY + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FILL_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                din_q, din_d;
  logic                we_q, we_d;
  logic                map_valid_q, map_valid_d;
  logic [PipeLen-1:0]  valid_q, valid_d;
  logic                write_cycle;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = vid_addr_in;
    din_d       = din_q;
    we_d        = 1'b0;
    map_valid_d = map_valid_q;
    write_cycle = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fill_start_in) begin
          state_d     = StFill;
          cnt_d       = '0;
          map_valid_d = 1'b0;
        end
      end
      StFill: begin
        if (!vid_active_in) begin
          write_cycle = 1'b1;
          we_d        = 1'b1;
          addr_d      = cnt_q;
          din_d       = fill_data_in;
          if (cnt_q == LastAddr) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        // A restart overrides completion, even on the final write.
        if (fill_start_in) begin
          state_d = StFill;
          cnt_d   = '0;
        end
      end
      StDone: begin
        if (fill_start_in) begin
          state_d = StFill;
          cnt_d   = '0;
        end else begin
          state_d     = StIdle;
          map_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    valid_d    = valid_q << 1;
    valid_d[0] = vid_active_in && !write_cycle;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      din_q       <= 1'b0;
      we_q        <= 1'b0;
      map_valid_q <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      map_valid_q <= map_valid_d;
      valid_q     <= valid_d;
    end
  end

  assign ram_addr_out   = addr_q;
  assign ram_din_out    = din_q;
  assign ram_we_out     = we_q;
  assign map_valid_out  = map_valid_q;
  assign vid_data_out   = ram_dout_in;
  assign vid_valid_out  = valid_q[PipeLen-1];
  assign fill_busy_out  = (state_q == StFill);
  assign fill_done_out  = (state_q == StDone);
  assign fill_ready_out = (state_q == StFill) && !vid_active_in;

endmodule

// File: tb/tb_terrain_ram_arbiter.sv
// Bench for terrain_ram_arbiter: directed vector table plus hand sequences, with a small
// behavioural BRAM and a reference model of the fill/read schedule.
module tb_terrain_ram_arbiter;

  localparam int LAST = 3599;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        vid_active_in = 1'b0;
  logic [15:0] vid_addr_in = '0;
  logic        fill_start_in = 1'b0;
  logic        fill_data_in = 1'b0;
  logic        vid_data_out, vid_valid_out, fill_ready_out, fill_busy_out;
  logic        fill_done_out, map_valid_out, ram_din_out, ram_we_out;
  logic [15:0] ram_addr_out;
  logic        ram_dout_in = 1'b0;
  logic        rd1 = 1'b0;
  bit          mem [65536];

  terrain_ram_arbiter #(
    .ADDR_W      (16),
    .FILL_WORDS  (3600),
    .RAM_LATENCY (2)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .vid_active_in  (vid_active_in),
    .vid_addr_in    (vid_addr_in),
    .vid_data_out   (vid_data_out),
    .vid_valid_out  (vid_valid_out),
    .fill_start_in  (fill_start_in),
    .fill_data_in   (fill_data_in),
    .fill_ready_out (fill_ready_out),
    .fill_busy_out  (fill_busy_out),
    .fill_done_out  (fill_done_out),
    .map_valid_out  (map_valid_out),
    .ram_addr_out   (ram_addr_out),
    .ram_din_out    (ram_din_out),
    .ram_we_out     (ram_we_out),
    .ram_dout_in    (ram_dout_in)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle read BRAM (address register in the DUT, output register here).
  always @(posedge clk_in) begin
    if (ram_we_out) mem[ram_addr_out] <= ram_din_out;
    rd1         <= mem[ram_addr_out];
    ram_dout_in <= rd1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  bit       m_fill = 0, m_done = 0, m_mv = 0;
  int       m_cnt = 0;
  logic [2:0] hist = '0;
  int       err_ready = 0, err_ram = 0, err_stat = 0, err_valid = 0;
  int       we_seen = 0;
  bit       done_seen = 0;

  typedef struct {
    logic        start, act;
    logic [15:0] addr;
    logic        data;
    logic        e_ready, e_we;
    logic [15:0] e_addr;
    logic        e_din, e_busy, e_done, e_mv, e_valid;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic phase(input string name);
    chk({name, "_ready"}, err_ready, 0);
    chk({name, "_ram"}, err_ram, 0);
    chk({name, "_status"}, err_stat, 0);
    chk({name, "_valid"}, err_valid, 0);
    err_ready = 0; err_ram = 0; err_stat = 0; err_valid = 0;
  endtask

  // One clock of stimulus, checked against the reference model.
  task automatic cyc(input bit start, input bit act, input logic [15:0] addr, input bit data);
    bit we_e, old_done;
    int e_addr;
    fill_start_in = start; vid_active_in = act; vid_addr_in = addr; fill_data_in = data;
    #1;
    if (fill_ready_out !== (m_fill && !act)) err_ready++;
    @(posedge clk_in); #1;
    fill_start_in = 1'b0;
    we_e     = m_fill && !act;
    e_addr   = we_e ? m_cnt : int'(addr);
    old_done = m_done;
    hist     = {hist[1:0], act};
    if (start) begin
      m_fill = 1; m_done = 0; m_cnt = 0; m_mv = 0;
    end else begin
      if (old_done) begin m_done = 0; m_mv = 1; end
      if (we_e) begin
        if (m_cnt == LAST) begin m_fill = 0; m_done = 1; end
        else m_cnt++;
      end
    end
    if (ram_we_out === 1'b1) we_seen++;
    if (fill_done_out === 1'b1) done_seen = 1;
    if (ram_we_out !== we_e || ram_addr_out !== 16'(e_addr) || (we_e && ram_din_out !== data))
      err_ram++;
    if (fill_busy_out !== m_fill || fill_done_out !== m_done || map_valid_out !== m_mv)
      err_stat++;
    if (vid_valid_out !== hist[2]) err_valid++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n_done;
    //          start act addr  data rdy we  addr  din busy done mv  valid
    vecs[0] = '{1'b0, 1'b1, 16'd7,  1'b0, 1'b0, 1'b0, 16'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'd9,  1'b0, 1'b0, 1'b0, 16'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'd11, 1'b0, 1'b0, 1'b0, 16'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 16'd5,  1'b1, 1'b1, 1'b1, 16'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 16'd6,  1'b0, 1'b1, 1'b1, 16'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 16'd20, 1'b0, 1'b0, 1'b0, 16'd20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 16'd21, 1'b1, 1'b1, 1'b1, 16'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'd22, 1'b1, 1'b1, 1'b1, 16'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    #3;
    chk("por_we", ram_we_out, 0);
    chk("por_busy", fill_busy_out, 0);
    #9 rst_in = 1'b1;

    for (int i = 0; i < 8; i++) begin
      fill_start_in = vecs[i].start; vid_active_in = vecs[i].act;
      vid_addr_in = vecs[i].addr; fill_data_in = vecs[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), fill_ready_out, vecs[i].e_ready);
      @(posedge clk_in); #1;
      chk($sformatf("v%0d_we", i), ram_we_out, vecs[i].e_we);
      chk($sformatf("v%0d_addr", i), ram_addr_out, vecs[i].e_addr);
      chk($sformatf("v%0d_din", i), ram_din_out, vecs[i].e_din);
      chk($sformatf("v%0d_busy", i), fill_busy_out, vecs[i].e_busy);
      chk($sformatf("v%0d_done", i), fill_done_out, vecs[i].e_done);
      chk($sformatf("v%0d_map_valid", i), map_valid_out, vecs[i].e_mv);
      chk($sformatf("v%0d_vid_valid", i), vid_valid_out, vecs[i].e_valid);
    end
    fill_start_in = 1'b0;

    // Reset in the middle of a fill.
    m_fill = 1; m_cnt = 4; m_done = 0; m_mv = 0; hist = 3'b100;
    while (m_cnt < 100) cyc(0, 0, 16'd0, bit'(m_cnt & 1));
    phase("pre_rst");
    #2 rst_in = 1'b0;
    #1;
    chk("rst_addr", ram_addr_out, 0);
    chk("rst_we", ram_we_out, 0);
    chk("rst_din", ram_din_out, 0);
    chk("rst_vid_valid", vid_valid_out, 0);
    chk("rst_busy", fill_busy_out, 0);
    chk("rst_done", fill_done_out, 0);
    chk("rst_map_valid", map_valid_out, 0);
    chk("rst_ready", fill_ready_out, 0);
    #2 rst_in = 1'b1;
    m_fill = 0; m_cnt = 0; m_done = 0; m_mv = 0; hist = '0;
    repeat (4) cyc(0, 0, 16'd0, 0);
    chk("post_rst_busy", fill_busy_out, 0);
    chk("post_rst_map_valid", map_valid_out, 0);
    phase("post_rst");

    // Full fill in blanking, alternating data.
    we_seen = 0; n_done = 0;
    cyc(1, 0, 16'd0, 0);
    n = 1;
    while (n_done == 0 && n < 4000) begin
      cyc(0, 0, 16'd0, bit'(m_cnt & 1));
      n++;
      if (fill_done_out === 1'b1) n_done = n;
    end
    chk("t2_done_cycle", n_done, 3601);
    chk("t2_writes", we_seen, 3600);
    cyc(0, 0, 16'd0, 0);
    chk("t2_map_valid", map_valid_out, 1);
    phase("t2");

    // Interleaved draw/blanking, fill of all ones.
    cyc(1, 1, 16'd100, 1);
    we_seen = 0;
    for (int c = 0; c < 9000 && (m_fill || m_done); c++) begin
      cyc(0, (c % 8) < 4, 16'(c), 1);
      if (c == 7) chk("t3_writes_per_8", we_seen, 4);
    end
    chk("t3_writes", we_seen, 3600);
    chk("t3_map_valid", map_valid_out, 1);
    phase("t3");

    // Read latency.
    repeat (4) cyc(0, 0, 16'd0, 0);
    cyc(0, 1, 16'd5, 0);
    chk("t4_valid_1", vid_valid_out, 0);
    cyc(0, 0, 16'd0, 0);
    chk("t4_valid_2", vid_valid_out, 0);
    cyc(0, 0, 16'd0, 0);
    chk("t4_valid_3", vid_valid_out, 1);
    chk("t4_data_3", vid_data_out, 1);
    cyc(0, 0, 16'd0, 0);
    chk("t4_valid_4", vid_valid_out, 0);
    cyc(0, 1, 16'd4000, 0);
    cyc(0, 0, 16'd0, 0);
    cyc(0, 0, 16'd0, 0);
    chk("t4_unwritten_valid", vid_valid_out, 1);
    chk("t4_unwritten_data", vid_data_out, 0);
    phase("t4");

    // Restart mid-fill, then restart on the final write.
    cyc(1, 0, 16'd0, 1);
    for (int k = 0; k < 2500 && m_cnt < 2000; k++) cyc(0, 0, 16'd0, 1);
    chk("t5_map_valid_mid", map_valid_out, 0);
    cyc(1, 1, 16'd7, 1);
    chk("t5_busy_restart", fill_busy_out, 1);
    chk("t5_done_restart", fill_done_out, 0);
    cyc(0, 0, 16'd0, 1);
    chk("t5_addr_after_restart", ram_addr_out, 0);
    chk("t5_we_after_restart", ram_we_out, 1);
    for (int k = 0; k < 4000 && m_cnt < LAST; k++) cyc(0, 0, 16'd0, 1);
    done_seen = 0;
    cyc(1, 0, 16'd0, 1);
    chk("t5_busy_last", fill_busy_out, 1);
    chk("t5_done_last", fill_done_out, 0);
    cyc(0, 0, 16'd0, 1);
    chk("t5_addr_after_last", ram_addr_out, 0);
    chk("t5_early_done", done_seen, 0);
    for (int k = 0; k < 4000 && m_fill; k++) cyc(0, 0, 16'd0, 1);
    chk("t5_done_final", fill_done_out, 1);
    cyc(0, 0, 16'd0, 0);
    chk("t5_map_valid_end", map_valid_out, 1);
    phase("t5");

    // Start during continuous active draw.
    we_seen = 0;
    cyc(1, 1, 16'd0, 0);
    for (int i = 0; i < 50; i++) cyc(0, 1, 16'(i), 0);
    chk("t6_writes", we_seen, 0);
    chk("t6_busy", fill_busy_out, 1);
    cyc(0, 0, 16'd0, 0);
    chk("t6_first_we", ram_we_out, 1);
    chk("t6_first_addr", ram_addr_out, 0);
    phase("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
